// File: rtl/ahb_lite_decoder_mux.sv
// AHB-lite interconnect stage. It decodes HADDR into one-hot slave selects and registers the data-phase select.
// It muxes the selected slave's response back to the master and captures error-response debug info.
module ahb_lite_decoder_mux #(
   parameter logic [31:0] S0_BASE = 32'h0000_0000,
   parameter logic [31:0] S0_MASK = 32'hF000_0000,
   parameter logic [31:0] S1_BASE = 32'h1000_0000,
   parameter logic [31:0] S1_MASK = 32'hF000_0000,
   parameter logic [31:0] S2_BASE = 32'h2000_0000,
   parameter logic [31:0] S2_MASK = 32'hFF00_0000
) (
   input  logic        HMASTCLOCK,
   input  logic        reset,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   output logic        HSEL0,
   output logic        HSEL1,
   output logic        HSEL2,
   output logic        HSEL_DEF,
   input  logic [31:0] HRDATA0,
   input  logic [31:0] HRDATA1,
   input  logic [31:0] HRDATA2,
   input  logic [31:0] HRDATA_DEF,
   input  logic        HREADYOUT0,
   input  logic        HREADYOUT1,
   input  logic        HREADYOUT2,
   input  logic        HREADYOUT_DEF,
   input  logic        HRESP0,
   input  logic        HRESP1,
   input  logic        HRESP2,
   input  logic        HRESP_DEF,
   output logic [31:0] HRDATA,
   output logic        HREADY,
   output logic        HRESP,
   input  logic        ERR_CLR,
   output logic [31:0] ERR_ADDR,
   output logic [7:0]  ERR_CNT
);

   typedef enum logic [2:0] {
      DSEL_NONE,
      DSEL_S0,
      DSEL_S1,
      DSEL_S2,
      DSEL_DEF
   } dsel_e;

   dsel_e       dsel_q, dsel_d, dec_sel;
   logic [31:0] haddr_dp_q, haddr_dp_d;
   logic [31:0] err_addr_q, err_addr_d;
   logic [7:0]  err_cnt_q, err_cnt_d;
   logic        m0, m1, m2, err_evt;
   logic        unused_htrans0;

   // HTRANS[0] only distinguishes IDLE/BUSY or NONSEQ/SEQ, which this stage does not care about.
   assign unused_htrans0 = HTRANS[0];

   assign m0 = (HADDR & S0_MASK) == S0_BASE;
   assign m1 = (HADDR & S1_MASK) == S1_BASE;
   assign m2 = (HADDR & S2_MASK) == S2_BASE;

   assign HSEL0    = m0;
   assign HSEL1    = !m0 && m1;
   assign HSEL2    = !m0 && !m1 && m2;
   assign HSEL_DEF = !(m0 || m1 || m2);

   always_comb begin
      dec_sel = DSEL_DEF;
      if (m0)      dec_sel = DSEL_S0;
      else if (m1) dec_sel = DSEL_S1;
      else if (m2) dec_sel = DSEL_S2;
   end

   // Only the slave owning the data phase reaches the master; the others may be driving anything.
   always_comb begin
      HRDATA = 32'h0;
      HREADY = 1'b1;
      HRESP  = 1'b0;
      case (dsel_q)
         DSEL_S0:  begin HRDATA = HRDATA0;    HREADY = HREADYOUT0;    HRESP = HRESP0;    end
         DSEL_S1:  begin HRDATA = HRDATA1;    HREADY = HREADYOUT1;    HRESP = HRESP1;    end
         DSEL_S2:  begin HRDATA = HRDATA2;    HREADY = HREADYOUT2;    HRESP = HRESP2;    end
         DSEL_DEF: begin HRDATA = HRDATA_DEF; HREADY = HREADYOUT_DEF; HRESP = HRESP_DEF; end
         default:  ;
      endcase
   end

   always_comb begin
      dsel_d     = dsel_q;
      haddr_dp_d = haddr_dp_q;
      if (HREADY) begin
         dsel_d = HTRANS[1] ? dec_sel : DSEL_NONE;
         if (HTRANS[1]) haddr_dp_d = HADDR;
      end
   end

   // Only the first (low-ready) cycle of the two-cycle error counts, so one event per transfer.
   assign err_evt = HRESP && !HREADY && (dsel_q != DSEL_NONE);

   always_comb begin
      err_addr_d = err_addr_q;
      err_cnt_d  = err_cnt_q;
      if (ERR_CLR) begin
         err_addr_d = 32'h0;
         err_cnt_d  = 8'h0;
      end else if (err_evt) begin
         err_addr_d = haddr_dp_q;
         if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'h1;
      end
   end

   always_ff @(posedge HMASTCLOCK or negedge reset) begin
      if (!reset) begin
         dsel_q     <= DSEL_NONE;
         haddr_dp_q <= 32'h0;
         err_addr_q <= 32'h0;
         err_cnt_q  <= 8'h0;
      end else begin
         dsel_q     <= dsel_d;
         haddr_dp_q <= haddr_dp_d;
         err_addr_q <= err_addr_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign ERR_ADDR = err_addr_q;
   assign ERR_CNT  = err_cnt_q;

endmodule

// File: doc/ahb_lite_decoder_mux.md
Name: ahb_lite_decoder_mux

Overview:
Interconnect stage between the single AHB-lite master and its slaves. Decodes HADDR into one-hot HSEL for three mapped slaves plus the default slave. Registers the address-phase selection into a data-phase select. Multiplexes the selected slave's HRDATA/HREADYOUT/HRESP back to the master and drives the shared HREADY. Also captures the address and count of error responses for debug.

Parameters:
S0_BASE, 32'h0000_0000, slave 0 base address
S0_MASK, 32'hF000_0000, slave 0 compare mask
S1_BASE, 32'h1000_0000, slave 1 base address
S1_MASK, 32'hF000_0000, slave 1 compare mask
S2_BASE, 32'h2000_0000, slave 2 base address
S2_MASK, 32'hFF00_0000, slave 2 compare mask

Ports:
HMASTCLOCK  in  1  bus clock, rising edge
reset  in  1  asynchronous, active-low reset
HADDR  in  32  master address
HTRANS  in  2  master transfer type
HSEL0, HSEL1, HSEL2  out  1 each  slave selects
HSEL_DEF  out  1  default slave select
HRDATA0, HRDATA1, HRDATA2, HRDATA_DEF  in  32 each  slave read data
HREADYOUT0, HREADYOUT1, HREADYOUT2, HREADYOUT_DEF  in  1 each  slave ready
HRESP0, HRESP1, HRESP2, HRESP_DEF  in  1 each  slave response
HRDATA  out  32  muxed read data to master
HREADY  out  1  muxed ready to master and to every slave HREADY input
HRESP  out  1  muxed response to master
ERR_CLR  in  1  synchronous clear of error capture
ERR_ADDR  out  32  address of most recent errored transfer
ERR_CNT  out  8  saturating error count

Behaviour:
- Decode is combinational from HADDR only and ignores HTRANS. Slave i matches when (HADDR & Si_MASK) == Si_BASE.
- Decode priority is S0 > S1 > S2. If none match, HSEL_DEF=1. Exactly one HSEL is high at all times.
- Data-phase state dsel has five states: NONE, S0, S1, S2, DEF. Reset value is NONE.
- dsel updates only at a rising edge with HREADY=1:
  - HTRANS[1]=0 (IDLE/BUSY) -> NONE.
  - Otherwise -> the decoded slave.
  - HREADY=0 -> dsel holds, so wait states extend the data phase.
- At the same edges (HREADY=1 and HTRANS[1]=1), haddr_d <= HADDR. Otherwise haddr_d holds. haddr_d resets to 0.
- Mux, combinational from dsel:
  - NONE: HRDATA=0, HREADY=1, HRESP=0.
  - Sx/DEF: the corresponding HRDATAx, HREADYOUTx, HRESPx.
  - Latency from slave outputs to master outputs is zero cycles.
- Two-cycle error response passes through unchanged:
  - HRESP=1, HREADY=0 holds dsel.
  - The next HRESP=1, HREADY=1 cycle closes the data phase and accepts the next address phase.
- Error capture:
  - Event = rising edge with HRESP=1, HREADY=0, dsel≠NONE, i.e. the first error cycle. Counts once per errored transfer, however many low-ready cycles it lasts.
  - On event: ERR_ADDR <= haddr_d; ERR_CNT increments and saturates at 8'hFF.
  - ERR_CLR=1 at an edge: ERR_CNT <= 0 and ERR_ADDR <= 0. Clear wins over a simultaneous event.
- reset low, asynchronous and at any time, including mid-transfer or mid-wait:
  - dsel=NONE, haddr_d=0, ERR_ADDR=0, ERR_CNT=0.
  - Outputs immediately become HRDATA=0, HREADY=1, HRESP=0.
  - HSEL outputs still follow HADDR.
- Slave outputs are ignored when dsel does not select them, including X values.

Test Plan:
- Reset release with HTRANS=IDLE, HADDR=0 -> HSEL0=1, HREADY=1, HRESP=0, HRDATA=0, ERR_CNT=0.
- NONSEQ read to 32'h1000_0040 with HREADY=1; next cycle HREADYOUT1=1, HRDATA1=32'hA5A5_0001 -> HSEL1=1 in address phase; next cycle HRDATA=32'hA5A5_0001, HREADY=1.
- Read to 32'h2000_0000 with HREADYOUT2 low for 3 cycles, then next address 32'h0000_0010 presented -> HREADY low 3 cycles, dsel stays S2, S0 selected only after HREADY=1.
- NONSEQ to 32'h8000_0004: HSEL_DEF=1; default slave returns HRESP=1/HREADYOUT=0 then HRESP=1/HREADYOUT=1 -> HRESP=1 for both cycles; ERR_ADDR=32'h8000_0004, ERR_CNT=1 (not 2).
- 256 back-to-back default-slave errors -> ERR_CNT=8'hFF. Then ERR_CLR asserted on an error event cycle -> ERR_CNT=0, ERR_ADDR=0.
- reset asserted while dsel=S1 and HREADYOUT1=0 -> HREADY=1, HRESP=0, HRDATA=0 immediately, without waiting for a clock edge; first transfer after release decodes normally.
